game_field_ctrl: RTL and testbench

- Initiator side of the generation handshake. Owns the authoritative current field and drives it to the simulator.
- Requests a new generation with a one-cycle pulse, then waits for the result's valid flag and captures the returned field.
- Provides run/pause, single-step, bulk load and per-cell toggle editing for the UI and display layers.

---
 rtl/game_config_pkg.sv | 21 ++
 rtl/game_tick_gen.sv | 30 +++
 rtl/game_field_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_field_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_config_pkg.sv
// Shared configuration for the game-of-life field controller: field geometry,
// edit coordinate widths, controller state encoding and the field image type.
package game_config;

    localparam int DEF_FIELD_W = 40;
    localparam int DEF_FIELD_H = 30;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    typedef enum logic [2:0] {
        CS_IDLE    = 3'd0,
        CS_REQ     = 3'd1,
        CS_WAIT    = 3'd2,
        CS_CAPTURE = 3'd3,
        CS_HALT    = 3'd4
    } ctrl_state_t;

    typedef logic [DEF_FIELD_H-1:0][DEF_FIELD_W-1:0] field_t;

endpackage

// File: rtl/game_tick_gen.sv
// Run-mode generation timer: counts enabled cycles and flags the last one of
// every TICK_CYCLES period, restarting from zero on expiry or clear.
module game_tick_gen #(
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_field_ctrl.sv
// Owns the authoritative life field and sequences generation requests to the
// simulator. Build with GAME_FIELD_CTRL_STILL_DETECT_EN to halt on still life.
module game_field_ctrl
    import game_config::*;
#(
    parameter int FIELD_W     = DEF_FIELD_W,
    parameter int FIELD_H     = DEF_FIELD_H,
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic                            step,
    input  logic                            load_vld,
    input  logic [FIELD_H-1:0][FIELD_W-1:0] load_field,
    input  logic                            edit_vld,
    input  logic [X_W-1:0]                  edit_x,
    input  logic [Y_W-1:0]                  edit_y,
    output logic [FIELD_H-1:0][FIELD_W-1:0] game_field,
    output logic                            go_next_state,
    input  logic [FIELD_H-1:0][FIELD_W-1:0] game_field_next,
    input  logic                            game_field_next_vld,
    output logic                            busy,
    output logic [15:0]                     generation,
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
    output logic                            still,
`endif
    output logic [2:0]                      dbg_state
);

    // Handshake: go_next_state is a one-cycle request; the simulator drops
    // game_field_next_vld on the edge that sees go, and raises it (level)
    // once game_field_next is complete. game_field stays stable meanwhile.

    localparam logic [2:0] S_IDLE    = CS_IDLE;
    localparam logic [2:0] S_REQ     = CS_REQ;
    localparam logic [2:0] S_WAIT    = CS_WAIT;
    localparam logic [2:0] S_CAPTURE = CS_CAPTURE;
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
    localparam logic [2:0] S_HALT    = CS_HALT;
`endif

    logic [2:0] state;
    logic       tick_pend;
    logic       tick_expire;
    logic       is_idle;
    logic       in_edit;
    logic       edit_ok;
    logic       field_wr;
    logic [FIELD_H-1:0][FIELD_W-1:0] edit_mask;
    logic [FIELD_H-1:0][FIELD_W-1:0] field_edited;

    assign is_idle = (state == S_IDLE);
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
    assign in_edit = is_idle || (state == S_HALT);
`else
    assign in_edit = is_idle;
`endif

    assign edit_ok  = edit_vld && (edit_x < X_W'(FIELD_W)) && (edit_y < Y_W'(FIELD_H));
    assign field_wr = in_edit && (load_vld || edit_ok);

    always_comb begin
        edit_mask = '0;
        for (int y = 0; y < FIELD_H; y++) begin
            for (int x = 0; x < FIELD_W; x++) begin
                if (int'(edit_y) == y && int'(edit_x) == x) begin
                    edit_mask[y][x] = 1'b1;
                end
            end
        end
    end

    // Load wins over a same-cycle toggle.
    assign field_edited = load_vld ? load_field : (game_field ^ edit_mask);

    assign go_next_state = (state == S_REQ);
    assign busy          = (state == S_REQ) || (state == S_WAIT);
    assign dbg_state     = state;

    game_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (run && is_idle),
        .clr   (!run || !is_idle || load_vld),
        .expire(tick_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            game_field <= '0;
            generation <= '0;
            tick_pend  <= 1'b0;
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
            still      <= 1'b0;
`endif
        end else begin
            if (field_wr) begin
                game_field <= field_edited;
                if (load_vld) begin
                    generation <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (field_wr) begin
                        // A tick landing on an edit cycle is served next cycle.
                        if (tick_expire) begin
                            tick_pend <= 1'b1;
                        end
                    end else if ((tick_pend && run) || tick_expire || (!run && step)) begin
                        state     <= S_REQ;
                        tick_pend <= 1'b0;
                    end
                    if (!run) begin
                        tick_pend <= 1'b0;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (game_field_next_vld) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    game_field <= game_field_next;
                    generation <= generation + 16'd1;
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
                    if (game_field_next == game_field) begin
                        still <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
                S_HALT: begin
                    tick_pend <= 1'b0;
                    if (field_wr) begin
                        still <= 1'b0;
                        state <= S_IDLE;
                    end else if (step) begin
                        still <= 1'b0;
                        state <= S_REQ;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_field_ctrl.sv
// Directed bench for game_field_ctrl with a behavioural simulator responder;
// the still-life section is compiled only with GAME_FIELD_CTRL_STILL_DETECT_EN.
module tb_game_field_ctrl;
    import game_config::*;

    localparam int TICKS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        load_vld = 1'b0;
    field_t      load_field = '0;
    logic        edit_vld = 1'b0;
    logic [5:0]  edit_x = '0;
    logic [4:0]  edit_y = '0;
    field_t      game_field;
    logic        go_next_state;
    field_t      nxt = '0;
    logic        vld = 1'b0;
    logic        busy;
    logic [15:0] generation;
    logic [2:0]  dbg_state;
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
    logic        still;
`endif

    game_field_ctrl #(
        .FIELD_W    (DEF_FIELD_W),
        .FIELD_H    (DEF_FIELD_H),
        .TICK_CYCLES(TICKS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .run                (run),
        .step               (step),
        .load_vld           (load_vld),
        .load_field         (load_field),
        .edit_vld           (edit_vld),
        .edit_x             (edit_x),
        .edit_y             (edit_y),
        .game_field         (game_field),
        .go_next_state      (go_next_state),
        .game_field_next    (nxt),
        .game_field_next_vld(vld),
        .busy               (busy),
        .generation         (generation),
`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
        .still              (still),
`endif
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_total = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (go_next_state) go_total <= go_total + 1;

    field_t pat_v, pat_h, pat_p, pat_blk;
    int resp_mode = 0;  // 0: xor P, 1: blinker swap, 2: identity
    int resp_delay = 10;

    function automatic field_t resp_fn(input field_t f);
        case (resp_mode)
            1:       return (f == pat_v) ? pat_h : pat_v;
            2:       return f;
            default: return f ^ pat_p;
        endcase
    endfunction

    function automatic int ones(input field_t f);
        int n = 0;
        for (int y = 0; y < DEF_FIELD_H; y++)
            for (int x = 0; x < DEF_FIELD_W; x++)
                n += int'(f[y][x]);
        return n;
    endfunction

    // Behavioural simulator: drops vld on the go edge, returns after resp_delay.
    always begin
        @(negedge clk);
        if (go_next_state && !rst) begin
            logic aborted;
            aborted = 1'b0;
            vld = 1'b0;
            for (int i = 0; i < resp_delay; i++) begin
                @(negedge clk);
                if (rst) aborted = 1'b1;
            end
            if (!aborted && !rst) begin
                nxt = resp_fn(game_field);
                vld = 1'b1;
            end
        end
        if (rst) vld = 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_field(input string name, input field_t exp);
        checks++;
        if (game_field !== exp) begin
            errors++;
            $display("FAIL %s field differs: actual_ones=%0d required_ones=%0d",
                     name, ones(game_field), ones(exp));
        end
    endtask

    task automatic wait_go(input string name, output int at_cyc);
        int n = 0;
        while (!go_next_state && n < 100) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
        if (!go_next_state) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for go_next_state", name);
        end
    endtask

    // Returns at the first idle cycle after capture (field already updated).
    task automatic wait_capture(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for busy low", name);
        end
        @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    typedef struct {
        logic        load;
        logic        edit;
        logic [5:0]  x;
        logic [4:0]  y;
        int          px;
        int          py;
        logic        exp_cell;
        int          exp_ones;
        logic [15:0] exp_gen;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t0, t1, g0;

        pat_v = '0; pat_v[4][10] = 1'b1; pat_v[5][10] = 1'b1; pat_v[6][10] = 1'b1;
        pat_h = '0; pat_h[5][9] = 1'b1; pat_h[5][10] = 1'b1; pat_h[5][11] = 1'b1;
        pat_p = '0; pat_p[0] = 40'h00_0000_00FF;
        pat_blk = '0;
        pat_blk[1][1] = 1'b1; pat_blk[1][2] = 1'b1; pat_blk[2][1] = 1'b1; pat_blk[2][2] = 1'b1;

        //            load  edit  x   y   px  py  cell ones gen
        vecs[0] = '{1'b0, 1'b1, 39, 29, 39, 29, 1'b1, 9, 16'd1};
        vecs[1] = '{1'b0, 1'b1, 39, 29, 39, 29, 1'b0, 8, 16'd1};
        vecs[2] = '{1'b0, 1'b1, 45,  3, 39,  3, 1'b0, 8, 16'd1};
        vecs[3] = '{1'b0, 1'b1,  5, 30,  5, 29, 1'b0, 8, 16'd1};
        vecs[4] = '{1'b0, 1'b1,  0,  0,  0,  0, 1'b0, 7, 16'd1};
        vecs[5] = '{1'b1, 1'b1, 10,  5, 10,  5, 1'b1, 3, 16'd0};
        vecs[6] = '{1'b0, 1'b1, 10,  4, 10,  4, 1'b0, 2, 16'd0};
        vecs[7] = '{1'b0, 1'b1, 10,  4, 10,  4, 1'b1, 3, 16'd0};

        // Reset values
        repeat (3) @(negedge clk);
        chk_field("reset_field", '0);
        chk("reset_go", 64'(go_next_state), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_gen", 64'(generation), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(CS_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Single step, slow simulator
        resp_mode = 0; resp_delay = 10;
        g0 = go_total;
        pulse_step();
        chk("step_go_rise", 64'(go_next_state), 64'd1);
        chk("step_busy_req", 64'(busy), 64'd1);
        @(negedge clk);
        chk("step_go_one_cycle", 64'(go_next_state), 64'd0);
        chk("step_busy_wait", 64'(busy), 64'd1);
        wait_capture("step");
        chk_field("step_field", pat_p);
        chk("step_gen", 64'(generation), 64'd1);
        chk("step_busy_done", 64'(busy), 64'd0);
        chk("step_go_count", 64'(go_total - g0), 64'd1);

        // Edit/load vector table, paused
        load_field = pat_v;
        foreach (vecs[i]) begin
            load_vld = vecs[i].load;
            edit_vld = vecs[i].edit;
            edit_x   = vecs[i].x;
            edit_y   = vecs[i].y;
            @(negedge clk);
            load_vld = 1'b0;
            edit_vld = 1'b0;
            chk($sformatf("vec%0d_cell", i), 64'(game_field[vecs[i].py][vecs[i].px]), 64'(vecs[i].exp_cell));
            chk($sformatf("vec%0d_ones", i), 64'(ones(game_field)), 64'(vecs[i].exp_ones));
            chk($sformatf("vec%0d_gen", i), 64'(generation), 64'(vecs[i].exp_gen));
        end

        // Edit during WAIT is dropped
        pulse_step();
        @(negedge clk);
        chk("wait_busy", 64'(busy), 64'd1);
        edit_vld = 1'b1; edit_x = 39; edit_y = 29;
        @(negedge clk);
        edit_vld = 1'b0;
        chk_field("wait_edit_dropped", pat_v);
        wait_capture("wait_edit");
        chk_field("wait_edit_capture", pat_v ^ pat_p);
        chk("wait_edit_gen", 64'(generation), 64'd1);

        // Blinker in run mode
        load_vld = 1'b1; load_field = pat_v;
        @(negedge clk);
        load_vld = 1'b0;
        chk("blink_load_gen", 64'(generation), 64'd0);
        resp_mode = 1; resp_delay = 3;
        run = 1'b1;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            wait_go($sformatf("blink%0d", k), t1);
            if (k > 0) chk($sformatf("blink%0d_spacing", k), 64'(t1 - t0), 64'd9);
            t0 = t1;
            wait_capture($sformatf("blink%0d", k));
            chk_field($sformatf("blink%0d_field", k), (k % 2 == 0) ? pat_h : pat_v);
            chk($sformatf("blink%0d_gen", k), 64'(generation), 64'(k + 1));
        end
        run = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in WAIT
        resp_mode = 0; resp_delay = 10;
        pulse_step();
        @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_field("rst_async_field", '0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_go", 64'(go_next_state), 64'd0);
        chk("rst_async_gen", 64'(generation), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        g0 = go_total;
        repeat (10) @(negedge clk);
        chk("rst_no_go", 64'(go_total - g0), 64'd0);
        chk("rst_idle", 64'(dbg_state), 64'(CS_IDLE));

`ifdef GAME_FIELD_CTRL_STILL_DETECT_EN
        // Still life halts run mode
        load_vld = 1'b1; load_field = pat_blk;
        @(negedge clk);
        load_vld = 1'b0;
        resp_mode = 2; resp_delay = 2;
        run = 1'b1;
        wait_go("still", t1);
        wait_capture("still");
        chk("still_set", 64'(still), 64'd1);
        chk("still_halt", 64'(dbg_state), 64'(CS_HALT));
        chk("still_gen", 64'(generation), 64'd1);
        g0 = go_total;
        repeat (12) @(negedge clk);
        chk("still_no_go", 64'(go_total - g0), 64'd0);
        pulse_step();
        chk("still_step_clear", 64'(still), 64'd0);
        chk("still_step_go", 64'(go_next_state), 64'd1);
        run = 1'b0;
        wait_capture("still_step");
        chk("still_step_gen", 64'(generation), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
